// File: rtl/seq_pkg.sv
// Shared definitions for the serial 1011 link: state encoding and default pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned     DEF_PLEN    = 4;
  localparam logic [DEF_PLEN-1:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_counter.sv
// Bit-serial overlapping pattern matcher; counts PATTERN hits (MSB first) since the last clr.
module pattern_counter import seq_pkg::*; #(
  parameter int unsigned     PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN,
  parameter int unsigned     CNTW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            bit_in,
  input  logic            bit_en,
  output logic [CNTW-1:0] cnt
);

  localparam int unsigned FW = $clog2(PLEN) + 1;
  localparam logic [FW-1:0] FULL = FW'(PLEN - 1);

  // Only the PLEN-1 most recent bits are kept; the incoming bit completes the window.
  logic [PLEN-2:0] hist_q, hist_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PLEN-1:0] window;
  logic            armed;

  always_comb begin
    window = {hist_q, bit_in};
    armed  = (fill_q == FULL);
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (bit_en) begin
      hist_d = window[PLEN-2:0];
      if (!armed) fill_d = fill_q + 1'b1;
      if (armed && (window == PATTERN) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_tx_1011.sv
// Serial pattern transmitter: loads a byte on set, shifts it out MSB first with dvalid,
// and counts overlapping PATTERN occurrences in the emitted frame.
module seq_tx_1011 import seq_pkg::*; #(
  parameter int unsigned     WIDTH   = 8,
  parameter int unsigned     PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN,
  parameter int unsigned     CNTW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [WIDTH-1:0] data,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  match_cnt,
  output logic [1:0]       now
);

  localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST = BCW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic             dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pc_clr, pc_en;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    dout_d   = 1'b0;
    dvalid_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (set) begin
          state_d  = ST_SHIFT;
          shreg_d  = data;
          bitcnt_d = '0;
          dout_d   = data[WIDTH-1];
          dvalid_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_SHIFT: begin
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q + 1'b1;
        busy_d   = 1'b1;
        if (bitcnt_q == LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          dout_d   = shreg_d[WIDTH-1];
          dvalid_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The bit on dout during SHIFT is the one retired at the coming edge.
  assign pc_clr = (state_q == ST_IDLE) && set;
  assign pc_en  = (state_q == ST_SHIFT);

  pattern_counter #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN),
    .CNTW    (CNTW)
  ) u_pattern_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (pc_clr),
    .bit_in (dout_q),
    .bit_en (pc_en),
    .cnt    (match_cnt)
  );

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign now    = state_q;

endmodule

// File: tb/tb_seq_tx_1011.sv
// Directed bench for seq_tx_1011: frame timing, match counts, reset abort, set collisions.
module tb_seq_tx_1011;

  logic       clk;
  logic       rst;
  logic       set;
  logic [7:0] data;
  logic       dout;
  logic       dvalid;
  logic       busy;
  logic       done;
  logic [3:0] match_cnt;
  logic [1:0] now;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  seq_tx_1011 #(
    .WIDTH (8),
    .CNTW  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .set       (set),
    .data      (data),
    .dout      (dout),
    .dvalid    (dvalid),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt),
    .now       (now)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance through one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input logic [3:0] exp_cnt);
    check("idle_now",    32'(now),       32'd0);
    check("idle_dvalid", 32'(dvalid),    32'd0);
    check("idle_dout",   32'(dout),      32'd0);
    check("idle_busy",   32'(busy),      32'd0);
    check("idle_done",   32'(done),      32'd0);
    check("idle_cnt",    32'(match_cnt), 32'(exp_cnt));
  endtask

  // Send one frame; with collide, set stays high one more cycle while data goes to 0.
  task automatic run_frame(input logic [7:0] d, input logic [3:0] exp_cnt, input bit collide);
    data = d;
    set  = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      check("shift_dout",   32'(dout),   32'(d[7-k]));
      check("shift_dvalid", 32'(dvalid), 32'd1);
      check("shift_busy",   32'(busy),   32'd1);
      check("shift_done",   32'(done),   32'd0);
      check("shift_now",    32'(now),    32'd1);
      if (k == 0 && collide) data = 8'h00;
      else set = 1'b0;
      tick();
    end
    check("done_pulse",  32'(done),      32'd1);
    check("done_dvalid", 32'(dvalid),    32'd0);
    check("done_dout",   32'(dout),      32'd0);
    check("done_busy",   32'(busy),      32'd1);
    check("done_now",    32'(now),       32'd2);
    check("done_cnt",    32'(match_cnt), 32'(exp_cnt));
    tick();
    check_idle(exp_cnt);
  endtask

  initial begin
    int unsigned seen_dv;
    int unsigned seen_done;
    int unsigned rise_cnt;
    int unsigned last_rise;
    logic        prev_dv;

    rst  = 1'b1;
    set  = 1'b0;
    data = 8'h00;
    tick();
    tick();
    check_idle(4'd0);
    rst = 1'b0;
    seen_dv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dvalid) seen_dv++;
    end
    check("idle_no_dvalid", seen_dv, 0);

    run_frame(8'b1011_1011, 4'd2, 1'b0);
    run_frame(8'b1011_0110, 4'd2, 1'b0);
    run_frame(8'b0000_0000, 4'd0, 1'b0);
    run_frame(8'b0011_0110, 4'd1, 1'b0);

    // Mid-frame reset: rst sampled at E+4.
    data = 8'b1011_1011;
    set  = 1'b1;
    tick();
    set = 1'b0;
    tick();
    tick();
    tick();
    check("pre_abort_dvalid", 32'(dvalid), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_dvalid", 32'(dvalid),    32'd0);
    check("abort_cnt",    32'(match_cnt), 32'd0);
    check("abort_now",    32'(now),       32'd0);
    check("abort_busy",   32'(busy),      32'd0);
    tick();
    rst = 1'b0;
    seen_dv   = 0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dvalid) seen_dv++;
      if (done) seen_done++;
    end
    check("abort_no_dvalid", seen_dv,   0);
    check("abort_no_done",   seen_done, 0);
    check("abort_cnt_held",  32'(match_cnt), 32'd0);
    run_frame(8'b0011_0110, 4'd1, 1'b0);

    run_frame(8'b1011_1011, 4'd2, 1'b1);

    // Continuous set: frames start every WIDTH+2 = 10 cycles.
    data      = 8'b1011_0110;
    set       = 1'b1;
    prev_dv   = 1'b0;
    rise_cnt  = 0;
    last_rise = 0;
    seen_done = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (dvalid && !prev_dv) begin
        if (rise_cnt > 0) check("b2b_spacing", 32'(i - last_rise), 32'd10);
        rise_cnt++;
        last_rise = i;
      end
      if (done) begin
        check("b2b_cnt", 32'(match_cnt), 32'd2);
        seen_done++;
      end
      prev_dv = dvalid;
    end
    check("b2b_frames", rise_cnt,  4);
    check("b2b_dones",  seen_done, 4);
    set = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
